// File: rtl/mips_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencing controller for the MIPS core.
// Optional performance counters are compiled in when MIPS_CTRL_PERF_EN is defined.
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op_class,
  input  logic       br_taken,
  input  logic       icache_ready,
  input  logic       dcache_ready,
  output logic       icache_rd_en,
  output logic       ir_load,
  output logic       rf_rd_en,
  output logic       alu_en,
  output logic       dcache_rd_en,
  output logic       dcache_wr_en,
  output logic       rf_wr_en,
  output logic       wb_sel,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       illegal_instr,
  output logic       mem_err,
  output logic [2:0] state_o
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned TO_W = 8;

  localparam logic [2:0] OP_ALU_R   = 3'd0;
  localparam logic [2:0] OP_ALU_I   = 3'd1;
  localparam logic [2:0] OP_LW      = 3'd2;
  localparam logic [2:0] OP_SW      = 3'd3;
  localparam logic [2:0] OP_BR      = 3'd4;
  localparam logic [2:0] OP_J       = 3'd5;
  localparam logic [2:0] OP_JR      = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("mips_mc_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= OP_ALU_R;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next state and all enables; reset forces the FETCH request only.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    to_cnt_d      = to_cnt_q;
    icache_rd_en  = 1'b0;
    ir_load       = 1'b0;
    rf_rd_en      = 1'b0;
    alu_en        = 1'b0;
    dcache_rd_en  = 1'b0;
    dcache_wr_en  = 1'b0;
    rf_wr_en      = 1'b0;
    wb_sel        = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = PC_SEQ;
    illegal_instr = 1'b0;
    mem_err       = 1'b0;

    if (rst) begin
      icache_rd_en = 1'b1;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          icache_rd_en = 1'b1;
          if (icache_ready) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          rf_rd_en = 1'b1;
          op_d     = op_class;
          if (op_class == OP_ILLEGAL) begin
            illegal_instr = 1'b1;
            pc_en         = 1'b1;
            state_d       = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_en = 1'b1;
          unique case (op_q)
            OP_ALU_R, OP_ALU_I: state_d = S_WB;
            OP_LW, OP_SW: begin
              to_cnt_d = '0;
              state_d  = S_MEM;
            end
            OP_BR: begin
              pc_en   = 1'b1;
              pc_sel  = br_taken ? PC_BR : PC_SEQ;
              state_d = S_FETCH;
            end
            OP_J: begin
              pc_en   = 1'b1;
              pc_sel  = PC_J;
              state_d = S_FETCH;
            end
            default: begin
              pc_en   = 1'b1;
              pc_sel  = PC_JR;
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          dcache_rd_en = (op_q == OP_LW);
          dcache_wr_en = (op_q != OP_LW);
          // Completion wins over a timeout landing on the same cycle.
          if (dcache_ready) begin
            if (op_q == OP_LW) begin
              state_d = S_WB;
            end else begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
          end else if (to_cnt_q == TO_LAST) begin
            mem_err = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_WB: begin
          rf_wr_en = 1'b1;
          wb_sel   = (op_q == OP_LW);
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state_o = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall_c;

  always_comb begin
    stall_c   = ((state_q == S_FETCH) && !icache_ready) ||
                ((state_q == S_MEM) && !dcache_ready);
    retired_d = pc_en ? retired_q + CNT_W'(1) : retired_q;
    cycle_d   = cycle_q + CNT_W'(1);
    stall_d   = stall_c ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
  assign stall_cnt   = stall_q;
`endif

endmodule
